// File: rtl/lbp_pkg.sv
// Shared image geometry, state encoding and address helpers for the LBP host.
package lbp_pkg;

   localparam int IMG_W  = 128;
   localparam int IMG_H  = 128;
   localparam int ADDR_W = 14;
   localparam int PIX_W  = 8;
   localparam int NPIX   = IMG_W * IMG_H;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SERVE = 2'd1,
      DUMP  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Address layout is {row[6:0], col[6:0]}; the outer ring has no valid LBP code.
   function automatic logic is_border(input logic [ADDR_W-1:0] addr);
      logic [6:0] row;
      logic [6:0] col;
      row = addr[13:7];
      col = addr[6:0];
      return (row == 7'd0) || (row == 7'(IMG_H - 1)) ||
             (col == 7'd0) || (col == 7'(IMG_W - 1));
   endfunction

endpackage

// File: rtl/lbp_host_if.sv
// Bus bundle between the LBP host and its pixel source, LBP engine and result sink.
interface lbp_host_if;

   logic                        pix_in_valid;
   logic [lbp_pkg::PIX_W-1:0]   pix_in_data;
   logic                        pix_in_ready;

   logic [lbp_pkg::ADDR_W-1:0]  gray_addr;
   logic                        gray_req;
   logic                        gray_ready;
   logic [lbp_pkg::PIX_W-1:0]   gray_data;

   logic [lbp_pkg::ADDR_W-1:0]  lbp_addr;
   logic                        lbp_valid;
   logic [lbp_pkg::PIX_W-1:0]   lbp_data;
   logic                        finish;

   logic                        res_valid;
   logic [lbp_pkg::ADDR_W-1:0]  res_addr;
   logic [lbp_pkg::PIX_W-1:0]   res_data;
   logic                        res_ready;
   logic                        done;

   modport slave (
      input  pix_in_valid, pix_in_data, gray_addr, gray_req,
             lbp_addr, lbp_valid, lbp_data, finish, res_ready,
      output pix_in_ready, gray_ready, gray_data,
             res_valid, res_addr, res_data, done
   );

   modport master (
      output pix_in_valid, pix_in_data, gray_addr, gray_req,
             lbp_addr, lbp_valid, lbp_data, finish, res_ready,
      input  pix_in_ready, gray_ready, gray_data,
             res_valid, res_addr, res_data, done
   );

endinterface

// File: rtl/lbp_frame_ram.sv
// One full frame of storage: synchronous write port, asynchronous read port, no reset.
module lbp_frame_ram
   import lbp_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [PIX_W-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [PIX_W-1:0]  rdata
);

   logic [PIX_W-1:0] mem [NPIX];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lbp_host.sv
// Frame host for an LBP engine: loads a gray image, serves reads, collects codes, dumps results.
module lbp_host
   import lbp_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   lbp_host_if.slave  bus
);

   state_t            state;
   logic [ADDR_W-1:0] load_cnt;
   logic [ADDR_W-1:0] dump_cnt;
   logic              pix_ready_q;
   logic              gray_ready_q;
   logic              res_valid_q;
   logic              done_q;

   logic              gray_we;
   logic              lbp_we;
   logic [PIX_W-1:0]  gray_rd;
   logic [PIX_W-1:0]  res_rd;

   assign gray_we = (state == LOAD) && bus.pix_in_valid && pix_ready_q;
   assign lbp_we  = (state == SERVE) && bus.lbp_valid;

   // Handshake outputs are registered alongside the state so they change on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= LOAD;
         load_cnt     <= '0;
         dump_cnt     <= '0;
         pix_ready_q  <= 1'b1;
         gray_ready_q <= 1'b0;
         res_valid_q  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (bus.pix_in_valid && pix_ready_q) begin
                  load_cnt <= load_cnt + 1'b1;
                  if (load_cnt == LAST_ADDR) begin
                     state        <= SERVE;
                     pix_ready_q  <= 1'b0;
                     gray_ready_q <= 1'b1;
                  end
               end
            end
            SERVE: begin
               if (bus.finish) begin
                  state        <= DUMP;
                  gray_ready_q <= 1'b0;
                  res_valid_q  <= 1'b1;
               end
            end
            DUMP: begin
               if (bus.res_ready) begin
                  if (dump_cnt == LAST_ADDR) begin
                     state       <= DONE;
                     res_valid_q <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     dump_cnt <= dump_cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

   lbp_frame_ram u_gray_ram (
      .clk   (clk),
      .we    (gray_we),
      .waddr (load_cnt),
      .wdata (bus.pix_in_data),
      .raddr (bus.gray_addr),
      .rdata (gray_rd)
   );

   lbp_frame_ram u_res_ram (
      .clk   (clk),
      .we    (lbp_we),
      .waddr (bus.lbp_addr),
      .wdata (bus.lbp_data),
      .raddr (dump_cnt),
      .rdata (res_rd)
   );

   // gray_ready_q is high exactly in SERVE, so it doubles as the read enable.
   assign bus.gray_data    = (gray_ready_q && bus.gray_req) ? gray_rd : '0;
   assign bus.gray_ready   = gray_ready_q;
   assign bus.pix_in_ready = pix_ready_q;
   assign bus.res_valid    = res_valid_q;
   assign bus.res_addr     = dump_cnt;
   assign bus.res_data     = is_border(dump_cnt) ? '0 : res_rd;
   assign bus.done         = done_q;

endmodule
